word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 2, number of buffered input words (power of two, at least 2).
REQ-002 The block SHALL have one clock, clk, and one reset, reset; reset is synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port in1  input  32  word from the upstream FSM, valid while in_valid is high.
REQ-006 Port in_valid  input  1  upstream level-valid; the upstream holds it high while the word is stable.
REQ-007 Port out_byte  output  8  current byte, least significant first.
REQ-008 Port out_valid  output  1  out_byte is valid.
REQ-009 Port out_ready  input  1  downstream accepts out_byte this cycle.
REQ-010 Port busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-011 Port overflow  output  1  sticky; set when a word is dropped because the FIFO is full.

Function
REQ-012 A push SHALL occur on each cycle where in_valid=1 and the registered in_valid of the previous cycle was 0 (rising-edge detect); a held level SHALL push exactly once.
REQ-013 The pushed word SHALL be in1 as sampled on the push edge.
REQ-014 A push with the FIFO full and no pop in the same cycle SHALL drop the word and set overflow; a push with the FIFO full and a pop in the same cycle SHALL be accepted.
REQ-015 The FSM SHALL have states IDLE=0 and SEND=1, held in an 8-bit state register.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop into a 32-bit shift register, clear the 2-bit byte index, and go to SEND.
REQ-017 In SEND, out_valid SHALL be 1 and out_byte SHALL be shift[7:0].
REQ-018 In SEND, on out_ready=1 with index<3, the shift register SHALL shift right by 8 and the index SHALL increment.
REQ-019 On out_ready=1 with index=3: if the FIFO is non-empty, the FSM SHALL pop and reload in the same cycle and stay in SEND (no bubble); otherwise it SHALL go to IDLE and drop out_valid.
REQ-020 With out_ready=0, out_byte and out_valid SHALL hold stable.
REQ-021 Latency: a push at edge E0 SHALL give out_valid=1 after edge E2 when the FSM is IDLE.
REQ-022 In IDLE, out_valid SHALL be 0 and out_byte SHALL be 0.
REQ-023 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with full/empty taken from a count register.

Reset
REQ-024 While reset=1, the following SHALL all be cleared: FSM to IDLE, FIFO empty, shift register 0, index 0, out_byte=0, out_valid=0, busy=0, overflow=0, registered in_valid=0.
REQ-025 Reset mid-word SHALL discard the partially sent word and all buffered words.
REQ-026 in_valid=1 on the first cycle after reset SHALL count as a rising edge.

Structure
REQ-027 State encodings (IDLE, SEND) and BYTES_PER_WORD=4 SHALL live in the shared package serializer_pkg.
REQ-028 The buffer SHALL be a sub-module sync_fifo (parameters: width 32, depth FIFO_DEPTH; ports: push, pop, data in/out, full, empty).

Verification
REQ-029 The bench SHALL check: in1=0x44332211, in_valid 0->1 held, out_ready=1 -> bytes 0x11,0x22,0x33,0x44 on consecutive cycles starting 2 cycles after the push, then out_valid=0, and exactly one word is sent.
REQ-030 The bench SHALL check: two pulses, 0xAABBCCDD then 0x01020304, with out_ready=1 -> 8 consecutive valid bytes DD,CC,BB,AA,04,03,02,01 with no bubble.
REQ-031 The bench SHALL check: out_ready=0 for 5 cycles mid-word -> out_byte held and out_valid held at 1; the sequence resumes unchanged.
REQ-032 The bench SHALL check: FIFO_DEPTH=2 with out_ready=0, then 4 pulses -> the first word is in the shift register, 2 words are buffered, the 4th is dropped, overflow=1 and stays 1.
REQ-033 The bench SHALL check: reset after the 2nd byte of 0x44332211 -> out_valid=0 and busy=0 the next cycle, and no further bytes are sent.
REQ-034 The bench SHALL check: full FIFO with a push and pop in the same cycle -> the word is accepted and overflow stays 0.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: FSM state encodings and word geometry shared by the word serializer
package serializer_pkg;
  localparam logic [7:0] IDLE = 8'd0;
  localparam logic [7:0] SEND = 8'd1;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: count-based synchronous FIFO; ports clk, reset, push/data_in, pop/data_out, full, empty
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign data_out = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= data_in;
endmodule

// File: rtl/word_serializer.sv
// word_serializer: buffers 32-bit words on in_valid rising edges and emits them LSB byte first over out_byte/out_valid/out_ready; busy, sticky overflow
module word_serializer
  import serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in1,
  input  logic        in_valid,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        overflow
);
  logic in_valid_q, push, pop, full, empty, last;
  logic [7:0] state;
  logic [WORD_W-1:0] shift, fifo_out;
  logic [1:0] idx;
  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .data_in(in1),
    .pop(pop),
    .data_out(fifo_out),
    .full(full),
    .empty(empty)
  );
  assign push = in_valid && !in_valid_q;
  assign last = idx == 2'(BYTES_PER_WORD - 1);
  // reload on the last accepted byte keeps the byte stream free of bubbles
  assign pop = !empty && (state == IDLE || (state == SEND && out_ready && last));
  assign out_valid = state == SEND;
  assign out_byte = out_valid ? shift[7:0] : '0;
  assign busy = !empty || state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      idx <= '0;
      in_valid_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      if (push && full && !pop) overflow <= 1'b1;
      if (pop) begin
        shift <= fifo_out;
        idx <= '0;
        state <= SEND;
      end else if (state == SEND && out_ready) begin
        if (last) state <= IDLE;
        else begin
          shift <= shift >> 8;
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed and random checks of word_serializer against a queue-based reference model
module tb_word_serializer;
  localparam int DEPTH = 2;
  logic clk = 0, reset, in_valid, out_ready, out_valid, busy, overflow;
  logic [31:0] in1;
  logic [7:0] out_byte;
  int n_assert = 0, n_fail = 0, cyc = 0, first_cyc, push_cyc;
  logic [31:0] mq[$];
  logic [7:0] got[$], want[$];
  bit m_act, m_ovf, m_prev;
  logic [31:0] m_cur;
  int m_k;
  word_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .in1(in1),
    .in_valid(in_valid),
    .out_byte(out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    mq.delete();
    m_act = 0;
    m_ovf = 0;
    m_prev = 0;
    m_cur = 0;
    m_k = 0;
  endtask
  task automatic cycle(input bit r, input bit iv, input bit rdy, input logic [31:0] w);
    bit pushe, take, room;
    reset = r;
    in_valid = iv;
    in1 = w;
    out_ready = rdy;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_act));
    chk("out_byte", 32'(out_byte), m_act ? (m_cur >> (8 * m_k)) & 32'hff : 32'h0);
    chk("busy", 32'(busy), 32'(m_act || mq.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (!r && out_valid && rdy) got.push_back(out_byte);
    if (out_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
    if (r) m_reset();
    else begin
      pushe = iv && !m_prev;
      take = 0;
      if (m_act && rdy) begin
        if (m_k == 3) begin
          if (mq.size() > 0) take = 1;
          else m_act = 0;
        end else m_k++;
      end else if (!m_act && mq.size() > 0) take = 1;
      room = mq.size() < DEPTH || take;
      if (take) begin
        m_cur = mq.pop_front();
        m_k = 0;
        m_act = 1;
      end
      if (pushe) begin
        if (room) mq.push_back(w);
        else m_ovf = 1;
      end
      m_prev = iv;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) want.push_back(8'(w / (32'd1 << (8 * i))));
  endtask
  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(want[i]));
    got.delete();
    want.delete();
  endtask
  task automatic pulse(input bit rdy, input logic [31:0] w);
    cycle(0, 1, rdy, w);
    cycle(0, 0, rdy, 0);
  endtask
  initial begin
    reset = 1;
    in_valid = 0;
    in1 = 0;
    out_ready = 0;
    first_cyc = -1;
    m_reset();
    repeat (2) @(negedge clk);
    cycle(1, 0, 0, 0);
    // single word, level held, pushed exactly once, 2-cycle latency
    first_cyc = -1;
    push_cyc = cyc;
    repeat (8) cycle(0, 1, 1, 32'h44332211);
    repeat (3) cycle(0, 0, 1, 0);
    chk("latency", 32'(first_cyc - push_cyc), 32'd2);
    want = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk_stream("single");
    // two words back to back, no bubble
    cycle(1, 0, 0, 0);
    pulse(1, 32'hAABBCCDD);
    pulse(1, 32'h01020304);
    repeat (10) cycle(0, 0, 1, 0);
    want = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
    chk_stream("two");
    // stall mid-word
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 32'h44332211);
    repeat (3) cycle(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0);
      chk("hold_byte", 32'(out_byte), 32'h33);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    repeat (6) cycle(0, 0, 1, 0);
    want = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk_stream("stall");
    // overflow: one in shift, two buffered, fourth dropped
    cycle(1, 0, 0, 0);
    pulse(0, 32'h11111111);
    pulse(0, 32'h22222222);
    pulse(0, 32'h33333333);
    pulse(0, 32'h44444444);
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (20) cycle(0, 0, 1, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    add_word(32'h11111111);
    add_word(32'h22222222);
    add_word(32'h33333333);
    chk_stream("ovf");
    // reset after second byte
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 32'h44332211);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (8) cycle(0, 0, 1, 0);
    want = '{8'h11, 8'h22};
    chk_stream("rst_mid");
    // full FIFO with simultaneous push and pop
    cycle(1, 0, 0, 0);
    pulse(0, 32'hA0A1A2A3);
    pulse(0, 32'hB0B1B2B3);
    pulse(0, 32'hC0C1C2C3);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 32'hD0D1D2D3);
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    repeat (20) cycle(0, 0, 1, 0);
    chk("pushpop_ovf_end", 32'(overflow), 32'd0);
    add_word(32'hA0A1A2A3);
    add_word(32'hB0B1B2B3);
    add_word(32'hC0C1C2C3);
    add_word(32'hD0D1D2D3);
    chk_stream("pushpop");
    // random traffic against the model
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
